pipelined_adder: RTL and testbench

Parametrised, pipelined two-operand adder with carry-in, carry-out and signed-overflow flag. It splits a WIDTH-bit addition into STAGES equal chunks and resolves one chunk per cycle, with the carry registered between stages. Throughput is one addition per clock. Valid/ready handshakes on both sides let it sit in arithmetic datapaths between producer and consumer blocks that may stall.

---
 rtl/pipelined_adder_pkg.sv | 22 ++
 rtl/adder_slice.sv | 29 ++
 rtl/pipelined_adder.sv | 129 ++++++++++++
 tb/tb_pipelined_adder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared arithmetic helpers for the pipelined adder: chunk sizing and
// configuration legality.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Bits resolved per pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    // Legal when there is at least one stage, the adder is at least two bits
    // wide and the width splits evenly into chunks.
    function automatic bit config_ok(input int width, input int stages);
        if (stages < 1) begin
            return 1'b0;
        end
        return (width >= 2) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder for one chunk of the pipelined adder.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    logic [W:0] carry;

    // Ripple the carry bit by bit through the chunk.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sum      = '0;
        carry    = '0;
        carry[0] = ci;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co = carry[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder resolving one CHUNK per stage, with a single
// global stall and valid/ready handshakes on both sides.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_cfg_error
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    logic adv;

    // The whole pipeline moves together whenever the output slot is empty or drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unresolved on entry, and sum bits resolved on exit.
        localparam int IN_W   = WIDTH - k * CHUNK;
        localparam int DONE_W = (k + 1) * CHUNK;

        logic              valid_in;
        logic              ci_in;
        logic [IN_W-1:0]   a_in;
        logic [IN_W-1:0]   b_in;
        logic [CHUNK-1:0]  chunk_sum;
        logic              chunk_co;
        logic [DONE_W-1:0] sum_d;

        logic              valid_q;
        logic              carry_q;
        logic [DONE_W-1:0] sum_q;

        if (k == 0) begin : g_src
            assign valid_in = in_valid;
            assign ci_in    = cin;
            assign a_in     = i1;
            assign b_in     = i2;
            assign sum_d    = chunk_sum;
        end else begin : g_src
            assign valid_in = g_stage[k-1].valid_q;
            assign ci_in    = g_stage[k-1].carry_q;
            assign a_in     = g_stage[k-1].g_fwd.opa_q;
            assign b_in     = g_stage[k-1].g_fwd.opb_q;
            assign sum_d    = {chunk_sum, g_stage[k-1].sum_q};
        end

        // The chunk to resolve here always sits at bit 0 of the forwarded operands.
        adder_slice #(
            .W (CHUNK)
        ) u_slice (
            .a   (a_in[CHUNK-1:0]),
            .b   (b_in[CHUNK-1:0]),
            .ci  (ci_in),
            .sum (chunk_sum),
            .co  (chunk_co)
        );

        // Stage register: valid bit, sum chunks resolved so far, carry out of this chunk.
        always_ff @(posedge clk) begin
            // NOTE: reset is synchronous, so it is tested inside the clocked block;
            // non-blocking assignments make every stage load its predecessor's
            // pre-edge value regardless of block evaluation order.
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_in;
                carry_q <= chunk_co;
                sum_q   <= sum_d;
            end
        end

        if (IN_W > CHUNK) begin : g_fwd
            logic [IN_W-CHUNK-1:0] opa_q;
            logic [IN_W-CHUNK-1:0] opb_q;

            // Forward the unresolved operand chunks, shifted so the next one lands at bit 0.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (adv) begin
                    opa_q <= a_in[IN_W-1:CHUNK];
                    opb_q <= b_in[IN_W-1:CHUNK];
                end
            end
        end

        if (k == STAGES - 1) begin : g_flag
            logic ovf_q;

            // Signed overflow: like-signed operands whose sum flips the sign bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_in[IN_W-1] == b_in[IN_W-1]) &&
                             (chunk_sum[CHUNK-1] != a_in[IN_W-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign c         = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_flag.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors on a 4-stage
// instance plus a random sweep on 1-stage and 16-stage instances.
module tb_pipelined_adder;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
        logic [31:0]      stamp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid, in_ready, cin, out_valid, out_ready, c, ovf;
    logic [WIDTH-1:0] i1, i2, s;

    logic             sw_valid, sw_cin;
    logic [WIDTH-1:0] sw_a, sw_b;
    logic             r1_in_ready, r1_out_valid, r1_c, r1_ovf;
    logic [WIDTH-1:0] r1_s;
    logic             r16_in_ready, r16_out_valid, r16_c, r16_ovf;
    logic [WIDTH-1:0] r16_s;

    exp_t        cur_exp, sw_exp;
    exp_t        main_q[$];
    exp_t        q1[$];
    exp_t        q16[$];
    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int unsigned ncnt          = 0;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i1(i1), .i2(i2), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c(c), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r1_in_ready),
        .i1(sw_a), .i2(sw_b), .cin(sw_cin), .out_valid(r1_out_valid), .out_ready(1'b1),
        .s(r1_s), .c(r1_c), .ovf(r1_ovf)
    );

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r16_in_ready),
        .i1(sw_a), .i2(sw_b), .cin(sw_cin), .out_valid(r16_out_valid), .out_ready(1'b1),
        .s(r16_s), .c(r16_c), .ovf(r16_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Plain full-width reference: sum, carry-out and signed overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci);
        logic [WIDTH:0] full;
        exp_t           r;
        full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        r.s     = full[WIDTH-1:0];
        r.c     = full[WIDTH];
        r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        r.stamp = '0;
        return r;
    endfunction

    always @(posedge clk) ncnt <= ncnt + 1;

    // Scoreboard for the 4-stage instance: the front entry must be presented
    // every cycle out_valid is high (stall stability) and popped on transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            main_q.delete();
        end else begin
            if (out_valid) begin
                if (main_q.size() == 0) begin
                    check("stale_out", out_valid, 1'b0);
                end else begin
                    check("s", s, main_q[0].s);
                    check("c", c, main_q[0].c);
                    check("ovf", ovf, main_q[0].ovf);
                    if (out_ready) void'(main_q.pop_front());
                end
            end
            if (in_valid && in_ready) main_q.push_back(cur_exp);
        end
    end

    // Scoreboard for the 1-stage instance, including exact latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q1.delete();
        end else begin
            if (r1_out_valid) begin
                if (q1.size() == 0) begin
                    check("sw1_stale", r1_out_valid, 1'b0);
                end else begin
                    check("sw1_s", r1_s, q1[0].s);
                    check("sw1_c", r1_c, q1[0].c);
                    check("sw1_ovf", r1_ovf, q1[0].ovf);
                    check("sw1_latency", ncnt - q1[0].stamp, 1);
                    void'(q1.pop_front());
                end
            end
            if (sw_valid) check("sw1_in_ready", r1_in_ready, 1'b1);
            if (sw_valid && r1_in_ready) begin
                e       = sw_exp;
                e.stamp = ncnt;
                q1.push_back(e);
            end
        end
    end

    // Scoreboard for the 16-stage instance, including exact latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q16.delete();
        end else begin
            if (r16_out_valid) begin
                if (q16.size() == 0) begin
                    check("sw16_stale", r16_out_valid, 1'b0);
                end else begin
                    check("sw16_s", r16_s, q16[0].s);
                    check("sw16_c", r16_c, q16[0].c);
                    check("sw16_ovf", r16_ovf, q16[0].ovf);
                    check("sw16_latency", ncnt - q16[0].stamp, 16);
                    void'(q16.pop_front());
                end
            end
            if (sw_valid) check("sw16_in_ready", r16_in_ready, 1'b1);
            if (sw_valid && r16_in_ready) begin
                e       = sw_exp;
                e.stamp = ncnt;
                q16.push_back(e);
            end
        end
    end

    // One operand pair into an empty pipeline; out_valid must rise exactly 4 cycles later.
    task automatic single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        in_valid = 1'b1;
        i1       = a;
        i2       = b;
        cin      = ci;
        cur_exp  = '{s: es, c: ec, ovf: eo, stamp: 32'd0};
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat_valid", out_valid, k == 4);
        end
    endtask

    initial begin
        int   idx;
        logic accepted;
        logic [WIDTH-1:0] a, b;
        logic ci;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        i1        = '0;
        i2        = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        cur_exp   = '0;
        sw_valid  = 1'b0;
        sw_a      = '0;
        sw_b      = '0;
        sw_cin    = 1'b0;
        sw_exp    = '0;

        // Reset state; out_ready low so in_ready=1 can only come from an empty output.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_s", s, 16'h0000);
        check("rst_c", c, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed vectors with hand-computed results.
        single(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        single(16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
        single(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        single(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Back-to-back: 8 pairs accepted on consecutive edges, 8 results on consecutive cycles.
        @(posedge clk); #1;
        for (int n = 0; n < 13; n++) begin
            if (n < 8) begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                ci       = 1'($urandom);
                in_valid = 1'b1;
                i1       = a;
                i2       = b;
                cin      = ci;
                cur_exp  = model(a, b, ci);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("b2b_valid", out_valid, (n >= 4) && (n <= 11));
            @(posedge clk); #1;
        end

        // Backpressure: 6 pairs, consumer stalls for 3 cycles mid-stream.
        idx      = 0;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            if (accepted) idx++;
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                a       = 16'($urandom);
                b       = 16'($urandom);
                ci      = 1'($urandom);
                i1      = a;
                i2      = b;
                cin     = ci;
                cur_exp = model(a, b, ci);
            end
            @(negedge clk);
            accepted = in_valid && in_ready;
            if (!out_ready) check("stall_in_ready", in_ready, 1'b0);
        end
        check("bp_all_sent", idx, 6);
        check("bp_drained", main_q.size(), 0);

        // Reset mid-flight: three pairs in the pipe, then a one-cycle reset.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'b1;
            i1       = a;
            i2       = b;
            cin      = 1'b0;
            cur_exp  = model(a, b, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_s", s, 16'h0000);
        check("midrst_c", c, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 1'b0);
        end

        // Random sweep on the 1-stage and 16-stage instances with gaps in the stream.
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            ci       = 1'($urandom);
            sw_valid = ($urandom_range(0, 3) != 0);
            sw_a     = a;
            sw_b     = b;
            sw_cin   = ci;
            sw_exp   = model(a, b, ci);
        end
        @(posedge clk); #1;
        sw_valid = 1'b0;

        // Bounded drain, then every queued result must have been delivered.
        repeat (24) @(posedge clk);
        @(negedge clk);
        check("main_drain", main_q.size(), 0);
        check("sw1_drain", q1.size(), 0);
        check("sw16_drain", q16.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
